// File: rtl/serial_pair_serializer.sv
// serial_pair_serializer: accepts an operand pair, emits a clear pulse, then streams both operands LSB-first
module serial_pair_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             clr_out,
    output logic             a_out,
    output logic             b_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int GW = $clog2(GAP + 1) + 1;
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, GAP_ST} state_t;
    state_t state;
    logic [WIDTH-1:0] sh1, sh2;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    // outputs are registered alongside the next state, so each reflects the cycle it is visible in
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sh1       <= '0;
            sh2       <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            in_ready  <= 1'b0;
            clr_out   <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            clr_out   <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sh1      <= num1;
                        sh2      <= num2;
                        cnt      <= '0;
                        state    <= CLEAR;
                        in_ready <= 1'b0;
                        clr_out  <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    state     <= SHIFT;
                    a_out     <= sh1[0];
                    b_out     <= sh2[0];
                    bit_valid <= 1'b1;
                    sh1       <= sh1 >> 1;
                    sh2       <= sh2 >> 1;
                end
                SHIFT: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        gcnt <= '0;
                        if (GAP > 0) begin
                            state <= GAP_ST;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        a_out     <= sh1[0];
                        b_out     <= sh2[0];
                        bit_valid <= 1'b1;
                        last_bit  <= (cnt == CW'(WIDTH - 2));
                        sh1       <= sh1 >> 1;
                        sh2       <= sh2 >> 1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                GAP_ST: begin
                    if (gcnt == GW'(GAP - 1)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pair_serializer.sv
// tb_serial_pair_serializer: scoreboarded bit streams plus directed handshake and frame timing checks
module tb_serial_pair_serializer;
    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_valid0 = 1'b0;
    logic [7:0] num1 = '0, num2 = '0;
    logic in_ready, clr_out, a_out, b_out, bit_valid, last_bit, busy;
    logic in_ready0, clr0, a0, b0, bv0, last0, busy0;
    typedef struct packed {logic a; logic b; logic l;} bit_t;
    bit_t q[$];
    int tests = 0, fails = 0;

    serial_pair_serializer #(.WIDTH(8), .GAP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .clr_out(clr_out), .a_out(a_out), .b_out(b_out),
        .bit_valid(bit_valid), .last_bit(last_bit), .busy(busy));

    serial_pair_serializer #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .num1(num1), .num2(num2), .clr_out(clr0), .a_out(a0), .b_out(b0),
        .bit_valid(bv0), .last_bit(last0), .busy(busy0));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {in_ready, clr_out, a_out, b_out, bit_valid, last_bit, busy};
    endfunction

    // sequences are written first-bit-leftmost, exactly as listed in the test plan
    task automatic push(input logic [7:0] as, input logic [7:0] bs, input int n);
        bit_t e;
        for (int i = 0; i < n; i++) begin
            e.a = as[7-i];
            e.b = bs[7-i];
            e.l = (i == 7);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        bit_t e;
        if (bit_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected bit", 1, 0);
            else begin
                e = q.pop_front();
                chk("a_out", a_out, e.a);
                chk("b_out", b_out, e.b);
                chk("last_bit", last_bit, e.l);
            end
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 50 && in_ready !== 1'b1; k++) @(negedge clk);
        chk("in_ready timeout", k < 50, 1);
    endtask

    task automatic frame(input logic [7:0] n1, input logic [7:0] n2,
                         input logic [7:0] as, input logic [7:0] bs);
        int low;
        push(as, bs, 8);
        wait_ready();
        num1 = n1;
        num2 = n2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("clr_out pulse", clr_out, 1);
        chk("clr cycle bit_valid", bit_valid, 0);
        low = 0;
        while (in_ready !== 1'b1 && low < 40) begin
            low++;
            @(negedge clk);
        end
        chk("in_ready low cycles", low, 10);
    endtask

    initial begin
        int c1, c2, l1;
        logic bv_gap;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c1, c2, l1;
        logic bv_gap;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("outputs in reset", outs(), 7'b0000000);
        reset = 1'b1;
        @(negedge clk);
        chk("outputs after reset", outs(), 7'b1000000);

        frame(8'd48, 8'd48, 8'b00001100, 8'b00001100);
        frame(8'd32, 8'd11, 8'b00000100, 8'b11010000);
        frame(8'd37, 8'd53, 8'b10100100, 8'b10101100);

        // back-to-back with in_valid held; operands change during frame 1
        push(8'b10100100, 8'b10101100, 8);
        push(8'b00000100, 8'b11010000, 8);
        wait_ready();
        num1 = 8'd37;
        num2 = 8'd53;
        in_valid = 1'b1;
        c1 = -1;
        c2 = -1;
        bv_gap = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                num1 = 8'd32;
                num2 = 8'd11;
            end
            if (clr_out === 1'b1) begin
                if (c1 < 0) c1 = k;
                else if (c2 < 0) begin
                    c2 = k;
                    in_valid = 1'b0;
                end
            end
            if (k >= 10 && k <= 12) bv_gap = bv_gap | bit_valid;
        end
        in_valid = 1'b0;
        chk("b2b first clr", c1, 1);
        chk("b2b clr spacing", c2 - c1, 11);
        chk("b2b gap bit_valid", bv_gap, 0);
        wait_ready();

        // reset during the 4th bit of 37/53
        push(8'b10100100, 8'b10101100, 4);
        num1 = 8'd37;
        num2 = 8'd53;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort outputs", outs(), 7'b0000000);
        reset = 1'b1;
        @(negedge clk);
        chk("post-abort ready", outs(), 7'b1000000);
        frame(8'd48, 8'd48, 8'b00001100, 8'b00001100);

        // GAP=0 instance: two back-to-back pairs
        c1 = -1;
        c2 = -1;
        l1 = -1;
        bv_gap = 1'b0;
        chk("gap0 ready", in_ready0, 1);
        in_valid0 = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (last0 === 1'b1 && l1 < 0) l1 = k;
            if (k == 10) bv_gap = bv0;
            if (clr0 === 1'b1) begin
                if (c1 < 0) c1 = k;
                else if (c2 < 0) begin
                    c2 = k;
                    in_valid0 = 1'b0;
                end
            end
        end
        in_valid0 = 1'b0;
        chk("gap0 period", c2 - c1, 10);
        chk("gap0 last_bit to clr", c2 - l1, 2);
        chk("gap0 idle bit_valid", bv_gap, 0);

        repeat (20) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
